irq_ctrl_n: RTL

- Parametrised successor to the SoC's fixed 4-input interrupt controller.
- Aggregates NUM_IRQ peripheral interrupt lines into one CPU interrupt.
- Per-source enable, per-source edge/level mode, software trigger, and a priority-encoded vector register.
- Sits on one AXI4-Lite peripheral port of the SoC distributor.

---
 rtl/irq_ctrl_n_pkg.sv | 44 ++++
 rtl/irq_ctrl_n_if.sv | 32 +++
 rtl/irq_ctrl_n_prio.sv | 22 ++
 rtl/irq_ctrl_n.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_n_pkg.sv
// Shared constants for irq_ctrl_n: register offsets, vector layout and the offset decoder.
package irq_ctrl_n_pkg;

   localparam logic [7:0] OFF_STATUS = 8'h00;
   localparam logic [7:0] OFF_SET    = 8'h04;
   localparam logic [7:0] OFF_ENABLE = 8'h08;
   localparam logic [7:0] OFF_MODE   = 8'h0C;
   localparam logic [7:0] OFF_MASTER = 8'h10;
   localparam logic [7:0] OFF_VECTOR = 8'h14;

   localparam int unsigned VEC_W         = 6;
   localparam int unsigned VEC_VALID_BIT = 5;

   typedef enum logic [2:0] {
      SEL_STATUS,
      SEL_SET,
      SEL_ENABLE,
      SEL_MODE,
      SEL_MASTER,
      SEL_VECTOR,
      SEL_NONE
   } reg_sel_e;

   function automatic reg_sel_e decode_offset(input logic [7:0] off);
      case (off)
         OFF_STATUS: return SEL_STATUS;
         OFF_SET:    return SEL_SET;
         OFF_ENABLE: return SEL_ENABLE;
         OFF_MODE:   return SEL_MODE;
         OFF_MASTER: return SEL_MASTER;
         OFF_VECTOR: return SEL_VECTOR;
         default:    return SEL_NONE;
      endcase
   endfunction

   function automatic logic [VEC_W-1:0] pack_vec(input logic valid, input logic [4:0] idx);
      logic [VEC_W-1:0] v;
      v                = '0;
      v[4:0]           = idx;
      v[VEC_VALID_BIT] = valid;
      return v;
   endfunction

endpackage

// File: rtl/irq_ctrl_n_if.sv
// AXI4-Lite configuration port of irq_ctrl_n; master = bus side, slave = controller side.
interface irq_ctrl_n_if;

   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

endinterface

// File: rtl/irq_ctrl_n_prio.sv
// Lowest-index-wins priority encoder; purely combinational, index is 0 when nothing requests.
module irq_prio_enc #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] req_i,
   output logic         valid_o,
   output logic [4:0]   idx_o
);

   // Scanning from the top down lets the lowest set bit overwrite all others.
   always_comb begin
      idx_o = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o = 5'(i);
         end
      end
   end

   assign valid_o = |req_i;

endmodule

// File: rtl/irq_ctrl_n.sv
// NUM_IRQ-source interrupt controller on an AXI4-Lite port.
// Define IRQ_CTRL_N_SYNC_EN to add a 2-flop synchroniser on every irq_i bit.
module irq_ctrl_n
   import irq_ctrl_n_pkg::*;
#(
   parameter int unsigned NUM_IRQ    = 8,
   parameter logic [31:0] RESET_MODE = 32'h0
) (
   input  logic               clk_i,
   input  logic               rst_i,
   irq_ctrl_n_if.slave        cfg_io,
   input  logic [NUM_IRQ-1:0] irq_i,
   output logic               intr_o,
   output logic [VEC_W-1:0]   irq_vec_o
);

   genvar gi;

   logic [NUM_IRQ-1:0] irq_s;
   logic [NUM_IRQ-1:0] irq_hist_q;
   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [NUM_IRQ-1:0] enable_q, enable_d;
   logic [NUM_IRQ-1:0] mode_q, mode_d;
   logic               master_q, master_d;
   logic [NUM_IRQ-1:0] set_pulse, w1c_pulse;
   logic [NUM_IRQ-1:0] active;
   logic               prio_valid;
   logic [4:0]         prio_idx;
   logic               intr_q;
   logic [VEC_W-1:0]   vec_q;
   logic               bvalid_q, bvalid_d;
   logic               rvalid_q, rvalid_d;
   logic [31:0]        rdata_q, rdata_d;
   logic [31:0]        rd_word;
   logic               wr_en, rd_en;
   reg_sel_e           wr_sel, rd_sel;

`ifdef IRQ_CTRL_N_SYNC_EN
   logic [NUM_IRQ-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= irq_i;
         sync2_q <= sync1_q;
      end
   end

   assign irq_s = sync2_q;
`else
   assign irq_s = irq_i;
`endif

   // Address and data must arrive together; one write response outstanding at most.
   assign wr_en          = cfg_io.awvalid & cfg_io.wvalid & ~bvalid_q;
   assign cfg_io.awready = wr_en;
   assign cfg_io.wready  = wr_en;
   assign wr_sel         = decode_offset(cfg_io.awaddr[7:0]);

   assign rd_en          = cfg_io.arvalid & ~rvalid_q;
   assign cfg_io.arready = ~rvalid_q;
   assign rd_sel         = decode_offset(cfg_io.araddr[7:0]);

   assign set_pulse = (wr_en && wr_sel == SEL_SET)    ? cfg_io.wdata[NUM_IRQ-1:0] : '0;
   assign w1c_pulse = (wr_en && wr_sel == SEL_STATUS) ? cfg_io.wdata[NUM_IRQ-1:0] : '0;

   for (gi = 0; gi < NUM_IRQ; gi++) begin : g_src
      logic rise;
      assign rise = irq_s[gi] & ~irq_hist_q[gi];
      // Edge sources latch until W1C (a simultaneous set wins); level sources track the input.
      assign pending_d[gi] = mode_q[gi]
                           ? (rise | set_pulse[gi] | (pending_q[gi] & ~w1c_pulse[gi]))
                           : (irq_s[gi] | set_pulse[gi]);
      assign enable_d[gi]  = (wr_en && wr_sel == SEL_ENABLE && cfg_io.wstrb[gi / 8])
                           ? cfg_io.wdata[gi] : enable_q[gi];
      assign mode_d[gi]    = (wr_en && wr_sel == SEL_MODE && cfg_io.wstrb[gi / 8])
                           ? cfg_io.wdata[gi] : mode_q[gi];
   end

   assign master_d = (wr_en && wr_sel == SEL_MASTER && cfg_io.wstrb[0])
                   ? cfg_io.wdata[0] : master_q;

   assign active = pending_q & enable_q;

   irq_prio_enc #(
      .N (NUM_IRQ)
   ) u_prio (
      .req_i   (active),
      .valid_o (prio_valid),
      .idx_o   (prio_idx)
   );

   always_comb begin
      rd_word = '0;
      case (rd_sel)
         SEL_STATUS: rd_word[NUM_IRQ-1:0] = pending_q;
         SEL_ENABLE: rd_word[NUM_IRQ-1:0] = enable_q;
         SEL_MODE:   rd_word[NUM_IRQ-1:0] = mode_q;
         SEL_MASTER: rd_word[0]           = master_q;
         SEL_VECTOR: rd_word[VEC_W-1:0]   = vec_q;
         default:    rd_word              = '0;
      endcase
   end

   assign bvalid_d = wr_en ? 1'b1 : (bvalid_q & ~cfg_io.bready);
   assign rvalid_d = rd_en ? 1'b1 : (rvalid_q & ~cfg_io.rready);
   assign rdata_d  = rd_en ? rd_word : rdata_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         irq_hist_q <= '0;
         pending_q  <= '0;
         enable_q   <= '0;
         mode_q     <= RESET_MODE[NUM_IRQ-1:0];
         master_q   <= 1'b0;
         intr_q     <= 1'b0;
         vec_q      <= '0;
         bvalid_q   <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
      end else begin
         irq_hist_q <= irq_s;
         pending_q  <= pending_d;
         enable_q   <= enable_d;
         mode_q     <= mode_d;
         master_q   <= master_d;
         intr_q     <= master_q & prio_valid;
         vec_q      <= pack_vec(prio_valid, prio_idx);
         bvalid_q   <= bvalid_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
      end
   end

   assign cfg_io.bvalid = bvalid_q;
   assign cfg_io.bresp  = 2'b00;
   assign cfg_io.rvalid = rvalid_q;
   assign cfg_io.rdata  = rdata_q;
   assign cfg_io.rresp  = 2'b00;
   assign intr_o        = intr_q;
   assign irq_vec_o     = vec_q;

   // Upper address bits and out-of-range data/strobe bits carry no meaning here.
   logic unused_cfg;
   assign unused_cfg = ^{cfg_io.awaddr, cfg_io.araddr, cfg_io.wdata, cfg_io.wstrb};

endmodule
